// File: rtl/zero_detect_scheduler_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// zds_pkg : shared state encoding and helpers for zero_detect_scheduler
// Revision: 1.0
// ----------------------------------------------------------------------------
package zds_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // One-hot (up to 8 requesters) to binary index; all-zero maps to 0.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/zero_detect_scheduler_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// zero_detect_scheduler_if : requester/result bus of the shared zero detector
// Revision: 1.0
// ----------------------------------------------------------------------------
interface zero_detect_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int WORD_W  = 8,
  parameter int CNT_W   = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*WORD_W-1:0] data;
  logic [NUM_REQ-1:0]        grant;
  logic                      busy;
  logic                      y_serial;
  logic                      done;
  logic [ID_W-1:0]           done_id;
  logic [CNT_W-1:0]          zero_count;

  modport master (
    output req, data,
    input  grant, busy, y_serial, done, done_id, zero_count
  );

  modport slave (
    input  req, data,
    output grant, busy, y_serial, done, done_id, zero_count
  );
endinterface
`default_nettype wire

// File: rtl/zero_detect_scheduler_zero_edge_detector.sv
`default_nettype none
// ----------------------------------------------------------------------------
// zero_edge_detector : 1-bit Mealy 1->0 transition detector, y = ~x & prev
// Revision: 1.0
// ----------------------------------------------------------------------------
module zero_edge_detector (
  input  wire logic clock,
  input  wire logic reset,
  input  wire logic clr,
  input  wire logic en,
  input  wire logic x,
  output logic      y
);

  logic prev_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_q <= 1'b0;
    end else if (clr) begin
      prev_q <= 1'b0;
    end else if (en) begin
      prev_q <= x;
    end
  end

  assign y = ~x & prev_q;

endmodule
`default_nettype wire

// File: rtl/zero_detect_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// zero_detect_scheduler : arbitrates NUM_REQ words onto one serial 1->0 detector
// Revision: 1.0  (ZDS_FIXED_PRIORITY_EN selects fixed priority over round-robin)
// ----------------------------------------------------------------------------
module zero_detect_scheduler
  import zds_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WORD_W  = 8,
  parameter int CNT_W   = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input wire logic                 clock,
  input wire logic                 reset,
  zero_detect_scheduler_if.slave   bus
);

  localparam int BCNT_W = $clog2(WORD_W + 1);

  state_t              state_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic                busy_q;
  logic                done_q;
  logic [ID_W-1:0]     done_id_q;
  logic [CNT_W-1:0]    zero_count_q;
  logic [CNT_W-1:0]    acc_q;
  logic [CNT_W-1:0]    acc_d;
  logic [WORD_W-1:0]   shreg_q;
  logic [BCNT_W-1:0]   bitcnt_q;
  logic [ID_W-1:0]     sel_idx_d;
  logic                sel_vld_d;
  logic [ID_W-1:0]     gnt_idx;
  logic                det_y;
  logic                y_gated;

`ifdef ZDS_FIXED_PRIORITY_EN
  always_comb begin
    sel_idx_d = '0;
    sel_vld_d = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        sel_idx_d = ID_W'(i);
        sel_vld_d = 1'b1;
      end
    end
  end
`else
  logic [ID_W-1:0]      rr_q;
  logic [2*NUM_REQ-1:0] req_dbl;

  // Doubling the request vector turns the wrap-around search into a plain scan.
  assign req_dbl = {bus.req, bus.req};

  always_comb begin
    sel_idx_d = '0;
    sel_vld_d = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_dbl[int'(rr_q) + k]) begin
        sel_idx_d = ID_W'((int'(rr_q) + k) % NUM_REQ);
        sel_vld_d = 1'b1;
      end
    end
  end
`endif

  assign gnt_idx = ID_W'(onehot_to_idx(8'(grant_q)));
  assign y_gated = det_y & (state_q == ST_SHIFT);
  assign acc_d   = (y_gated && (acc_q != '1)) ? acc_q + 1'b1 : acc_q;

  zero_edge_detector u_det (
    .clock (clock),
    .reset (reset),
    .clr   ((state_q == ST_IDLE) && sel_vld_d),
    .en    (state_q == ST_SHIFT),
    .x     (shreg_q[WORD_W-1]),
    .y     (det_y)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      done_id_q    <= '0;
      zero_count_q <= '0;
      acc_q        <= '0;
      shreg_q      <= '0;
      bitcnt_q     <= '0;
`ifndef ZDS_FIXED_PRIORITY_EN
      rr_q         <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sel_vld_d) begin
            grant_q  <= NUM_REQ'(1) << sel_idx_d;
            shreg_q  <= bus.data[int'(sel_idx_d)*WORD_W +: WORD_W];
            bitcnt_q <= '0;
            acc_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          shreg_q  <= {shreg_q[WORD_W-2:0], 1'b0};
          acc_q    <= acc_d;
          bitcnt_q <= bitcnt_q + 1'b1;
          if (bitcnt_q == BCNT_W'(WORD_W - 1)) begin
            state_q      <= ST_DONE;
            done_q       <= 1'b1;
            zero_count_q <= acc_d;
            done_id_q    <= gnt_idx;
            grant_q      <= '0;
`ifndef ZDS_FIXED_PRIORITY_EN
            rr_q         <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
`endif
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.grant      = grant_q;
  assign bus.busy       = busy_q;
  assign bus.y_serial   = y_gated;
  assign bus.done       = done_q;
  assign bus.done_id    = done_id_q;
  assign bus.zero_count = zero_count_q;

endmodule
`default_nettype wire

// File: tb/tb_zero_detect_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_zero_detect_scheduler : scoreboard bench with a transaction-level model
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_zero_detect_scheduler;

  localparam int NUM_REQ = 4;
  localparam int WORD_W  = 8;
  localparam int CNT_W   = 4;
  localparam int ID_W    = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  zero_detect_scheduler_if #(.NUM_REQ(NUM_REQ), .WORD_W(WORD_W), .CNT_W(CNT_W), .ID_W(ID_W)) bus ();

  zero_detect_scheduler #(.NUM_REQ(NUM_REQ), .WORD_W(WORD_W), .CNT_W(CNT_W), .ID_W(ID_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct { int id; int cnt; } exp_t;
  exp_t sb_q[$];

  int  vectors    = 0;
  int  miscompares = 0;
  int  cyc        = 0;
  bit  mon_en     = 1'b0;

  // Model: phase 0 idle, 1..WORD_W serial bits, WORD_W+1 result cycle.
  int                m_phase = 0;
  int                m_id    = 0;
  int                m_rr    = 0;
  logic [WORD_W-1:0] m_word  = '0;
  int                h_id    = 0;
  int                h_cnt   = 0;

  function automatic int count_falls(logic [WORD_W-1:0] w);
    int n = 0;
    for (int i = WORD_W - 1; i > 0; i--) if (w[i] && !w[i-1]) n++;
    return n;
  endfunction

  function automatic int pick(logic [NUM_REQ-1:0] r, int ptr);
    for (int off = 0; off < NUM_REQ; off++)
      if (r[(ptr + off) % NUM_REQ]) return (ptr + off) % NUM_REQ;
    return -1;
  endfunction

  task automatic chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) cyc++;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_phase = 0;
      m_rr    = 0;
      sb_q.delete();
    end else if (m_phase == 0) begin
      if (bus.req != '0) begin
`ifdef ZDS_FIXED_PRIORITY_EN
        m_id = pick(bus.req, 0);
`else
        m_id = pick(bus.req, m_rr);
`endif
        m_word = bus.data[m_id*WORD_W +: WORD_W];
        sb_q.push_back('{m_id, count_falls(m_word)});
        m_phase = 1;
      end
    end else if (m_phase <= WORD_W) begin
      m_phase++;
    end else begin
      m_phase = 0;
      m_rr    = (m_id + 1) % NUM_REQ;
    end
  end

  always @(negedge clock) begin
    if (mon_en) begin
      int   e_grant;
      int   k;
      logic e_y;
      exp_t e;
      if (reset) begin
        h_id  = 0;
        h_cnt = 0;
      end
      e_grant = (m_phase >= 1 && m_phase <= WORD_W) ? (1 << m_id) : 0;
      e_y     = 1'b0;
      if (m_phase >= 1 && m_phase <= WORD_W) begin
        k   = m_phase - 1;
        e_y = !m_word[WORD_W-1-k] && (k != 0) && m_word[WORD_W-k];
      end
      chk("grant", int'(bus.grant), e_grant);
      chk("busy", int'(bus.busy), int'(m_phase != 0));
      chk("y_serial", int'(bus.y_serial), int'(e_y));
      chk("done", int'(bus.done), int'(m_phase == WORD_W + 1));
      if (bus.done) begin
        if (sb_q.size() == 0) begin
          chk("done_without_request", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("done_id", int'(bus.done_id), e.id);
          chk("zero_count", int'(bus.zero_count), e.cnt);
          h_id  = e.id;
          h_cnt = e.cnt;
        end
      end else begin
        chk("held_done_id", int'(bus.done_id), h_id);
        chk("held_zero_count", int'(bus.zero_count), h_cnt);
      end
    end
  end

  task automatic do_reset();
    @(negedge clock);
    #2 reset = 1'b1;
    bus.req = '0;
    repeat (2) @(negedge clock);
    #2 reset = 1'b0;
  endtask

  task automatic wait_done(int id, int limit);
    int n = 0;
    while (!(bus.done && int'(bus.done_id) == id)) begin
      @(negedge clock);
      n++;
      if (n > limit) begin
        chk("timeout_done", n, limit);
        return;
      end
    end
  endtask

  task automatic wait_grant(int id, int limit);
    int n = 0;
    while (!bus.grant[id]) begin
      @(negedge clock);
      n++;
      if (n > limit) begin
        chk("timeout_grant", n, limit);
        return;
      end
    end
  endtask

  task automatic single(int id, logic [WORD_W-1:0] w);
    @(negedge clock);
    bus.data[id*WORD_W +: WORD_W] = w;
    bus.req[id] = 1'b1;
    wait_done(id, 30);
    bus.req[id] = 1'b0;
  endtask

  initial begin
    logic [WORD_W-1:0] words [5];
    int                exp_seq [5];
    int                last_cyc;
    int                n;
    words = '{8'b1010_1010, 8'h00, 8'hF0, 8'hFF, 8'b0110_0110};
`ifdef ZDS_FIXED_PRIORITY_EN
    exp_seq = '{0, 0, 0, 0, 0};
`else
    exp_seq = '{0, 1, 2, 3, 0};
`endif
    bus.req  = '0;
    bus.data = '0;
    repeat (3) @(negedge clock);
    mon_en = 1'b1;
    #2 reset = 1'b0;

    // Directed single words on requester 0.
    foreach (words[i]) single(0, words[i]);

    // All four requesting continuously.
    do_reset();
    @(negedge clock);
    bus.data = (NUM_REQ*WORD_W)'($urandom);
    bus.req  = '1;
    last_cyc = 0;
    for (int i = 0; i < 5; i++) begin
      n = 0;
      while (!bus.done && n < 30) begin @(negedge clock); n++; end
      chk("rr_order", int'(bus.done_id), exp_seq[i]);
      if (i > 0) chk("done_spacing", cyc - last_cyc, WORD_W + 2);
      last_cyc = cyc;
      @(negedge clock);
      bus.data = (NUM_REQ*WORD_W)'($urandom);
    end
    bus.req = '0;
    repeat (12) @(negedge clock);

    // Inputs change during SHIFT; latched word must be used.
    @(negedge clock);
    bus.data[0 +: WORD_W] = 8'b1101_0010;
    bus.req[0] = 1'b1;
    wait_grant(0, 5);
    repeat (3) @(negedge clock);
    bus.data[0 +: WORD_W] = 8'b0101_0101;
    bus.req[0] = 1'b0;
    wait_done(0, 30);
    repeat (2) @(negedge clock);

    // Reset in the fourth SHIFT cycle, then req2 alone.
    bus.data = (NUM_REQ*WORD_W)'($urandom);
    bus.req[0] = 1'b1;
    wait_grant(0, 5);
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    bus.req = '0;
    @(negedge clock);
    chk("grant_in_reset", int'(bus.grant), 0);
    chk("busy_in_reset", int'(bus.busy), 0);
    #2 reset = 1'b0;
    bus.req = 4'b0100;
    wait_grant(2, 5);
    chk("grant_after_reset", int'(bus.grant), 4);
    wait_done(2, 30);
    bus.req = '0;

    // Back-to-back: req1 raised in the DONE cycle of req0.
    single(0, 8'h3C);
    bus.req[1] = 1'b0;
    @(negedge clock);
    bus.data[0 +: WORD_W] = 8'hA5;
    bus.req[0] = 1'b1;
    wait_done(0, 30);
    bus.req[0] = 1'b0;
    bus.data[WORD_W +: WORD_W] = 8'h96;
    bus.req[1] = 1'b1;
    n = 0;
    while (!bus.grant[1] && n < 10) begin @(negedge clock); n++; end
    chk("b2b_latency", n, 2);
    wait_done(1, 30);
    bus.req[1] = 1'b0;

    // Random traffic.
    for (int i = 0; i < 25; i++) begin
      @(negedge clock);
      bus.data = (NUM_REQ*WORD_W)'($urandom);
      bus.req  = NUM_REQ'($urandom);
      repeat ($urandom_range(1, 12)) @(negedge clock);
    end
    bus.req = '0;
    n = 0;
    while (m_phase != 0 && n < 30) begin @(negedge clock); n++; end
    repeat (3) @(negedge clock);
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
